// File: rtl/llc_req_sequencer.sv
// Multi-channel LLC request sequencer: per-channel {op,addr} FIFOs arbitrated onto
// a single hold-stalled LLC request port, with saturating per-class statistics.
module llc_req_sequencer #(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 32,
  parameter int ARB_MODE   = 0,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*4-1:0]      in_op,
  input  logic [NUM_CH*ADDR_W-1:0] in_addr,
  output logic                     out_valid,
  output logic [3:0]               out_op,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     hold,
  output logic [CNT_W-1:0]         rd_cnt,
  output logic [CNT_W-1:0]         wr_cnt,
  output logic [CNT_W-1:0]         snoop_cnt,
  output logic [CNT_W-1:0]         illegal_cnt,
  output logic                     busy
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // state      | meaning
  // ST_EMPTY   | output register holds nothing, out_valid=0
  // ST_PRESENT | request presented to the LLC, waiting for !hold
  typedef enum logic {ST_EMPTY, ST_PRESENT} state_e;

  state_e state_q, state_d;

  logic [NUM_CH-1:0] fifo_empty, fifo_full, push_ok, push_bad, pop;
  logic [3:0]        head_op   [NUM_CH];
  logic [ADDR_W-1:0] head_addr [NUM_CH];

  logic              load, accept;
  logic              win_found;
  logic [CH_W-1:0]   win_ch;

  logic [CH_W-1:0]   rr_q, rr_d;
  logic [3:0]        out_op_q, out_op_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [CNT_W-1:0]  rd_q, rd_d, wr_q, wr_d, snoop_q, snoop_d, ill_q, ill_d;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= 4'd6) || (op == 4'd8) || (op == 4'd9);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]        op_mem_q   [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
    logic [3:0]        op_in;

    assign op_in         = in_op[4*c +: 4];
    // Full when the wrap bits differ but the index bits match.
    assign fifo_empty[c] = (wr_ptr_q == rd_ptr_q);
    assign fifo_full[c]  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                           (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign push_ok[c]    = in_valid[c] && !fifo_full[c] && op_legal(op_in);
    assign push_bad[c]   = in_valid[c] && !fifo_full[c] && !op_legal(op_in);
    assign pop[c]        = load && (win_ch == CH_W'(c));
    assign head_op[c]    = op_mem_q[rd_ptr_q[IDX_W-1:0]];
    assign head_addr[c]  = addr_mem_q[rd_ptr_q[IDX_W-1:0]];
    assign wr_ptr_d      = push_ok[c] ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d      = pop[c]     ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push_ok[c]) begin
        op_mem_q[wr_ptr_q[IDX_W-1:0]]   <= op_in;
        addr_mem_q[wr_ptr_q[IDX_W-1:0]] <= in_addr[ADDR_W*c +: ADDR_W];
      end
    end
  end

  always_comb begin
    int              sum;
    logic [CH_W-1:0] idx;
    win_found = 1'b0;
    win_ch    = '0;
    sum       = 0;
    idx       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ARB_MODE == 1) begin
        sum = i;
      end else begin
        sum = int'(rr_q) + i;
        if (sum >= NUM_CH) sum = sum - NUM_CH;
      end
      idx = CH_W'(sum);
      if (!win_found && !fifo_empty[idx]) begin
        win_found = 1'b1;
        win_ch    = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (win_found) begin
          load    = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (!hold) begin
          accept = 1'b1;
          if (win_found) load = 1'b1;
          else           state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_op_d   = out_op_q;
    out_addr_d = out_addr_q;
    out_ch_d   = out_ch_q;
    rr_d       = rr_q;
    if (load) begin
      out_op_d   = head_op[win_ch];
      out_addr_d = head_addr[win_ch];
      out_ch_d   = win_ch;
      rr_d       = (win_ch == CH_W'(NUM_CH - 1)) ? '0 : win_ch + 1'b1;
    end
  end

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    snoop_d = snoop_q;
    ill_d   = sat_add(ill_q, CNT_W'($countones(push_bad)));
    if (accept) begin
      case (out_op_q)
        4'd0, 4'd2:             rd_d    = sat_add(rd_q, CNT_W'(1));
        4'd1:                   wr_d    = sat_add(wr_q, CNT_W'(1));
        4'd3, 4'd4, 4'd5, 4'd6: snoop_d = sat_add(snoop_q, CNT_W'(1));
        default: ;
      endcase
      // Clear takes precedence over any increment landing in the same cycle.
      if (out_op_q == 4'd8) begin
        rd_d    = '0;
        wr_d    = '0;
        snoop_d = '0;
        ill_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      rr_q       <= '0;
      out_op_q   <= '0;
      out_addr_q <= '0;
      out_ch_q   <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      snoop_q    <= '0;
      ill_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      out_op_q   <= out_op_d;
      out_addr_q <= out_addr_d;
      out_ch_q   <= out_ch_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      snoop_q    <= snoop_d;
      ill_q      <= ill_d;
    end
  end

  assign in_ready    = ~fifo_full;
  assign out_valid   = (state_q == ST_PRESENT);
  assign out_op      = out_op_q;
  assign out_addr    = out_addr_q;
  assign out_ch      = out_ch_q;
  assign rd_cnt      = rd_q;
  assign wr_cnt      = wr_q;
  assign snoop_cnt   = snoop_q;
  assign illegal_cnt = ill_q;
  assign busy        = (|(~fifo_empty)) || out_valid;

endmodule

// File: tb/tb_llc_req_sequencer.sv
// Directed bench for llc_req_sequencer: round-robin, fixed-priority and 4-bit-counter
// instances share one stimulus stream; each step checks hand-computed values.
module tb_llc_req_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid;
  logic [15:0]  in_op;
  logic [127:0] in_addr;
  logic         hold;

  logic [3:0]  rr_in_ready, fp_in_ready, c4_in_ready;
  logic        rr_out_valid, fp_out_valid, c4_out_valid;
  logic [3:0]  rr_out_op, fp_out_op, c4_out_op;
  logic [31:0] rr_out_addr, fp_out_addr, c4_out_addr;
  logic [1:0]  rr_out_ch, fp_out_ch, c4_out_ch;
  logic [31:0] rr_rd, rr_wr, rr_snoop, rr_ill;
  logic [31:0] fp_rd, fp_wr, fp_snoop, fp_ill;
  logic [3:0]  c4_rd, c4_wr, c4_snoop, c4_ill;
  logic        rr_busy, fp_busy, c4_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  llc_req_sequencer #(.NUM_CH(4), .FIFO_DEPTH(4), .ADDR_W(32), .CNT_W(32), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rr_in_ready), .in_op(in_op),
    .in_addr(in_addr), .out_valid(rr_out_valid), .out_op(rr_out_op), .out_addr(rr_out_addr),
    .out_ch(rr_out_ch), .hold(hold), .rd_cnt(rr_rd), .wr_cnt(rr_wr), .snoop_cnt(rr_snoop),
    .illegal_cnt(rr_ill), .busy(rr_busy));

  llc_req_sequencer #(.NUM_CH(4), .FIFO_DEPTH(4), .ADDR_W(32), .CNT_W(32), .ARB_MODE(1)) u_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(fp_in_ready), .in_op(in_op),
    .in_addr(in_addr), .out_valid(fp_out_valid), .out_op(fp_out_op), .out_addr(fp_out_addr),
    .out_ch(fp_out_ch), .hold(hold), .rd_cnt(fp_rd), .wr_cnt(fp_wr), .snoop_cnt(fp_snoop),
    .illegal_cnt(fp_ill), .busy(fp_busy));

  llc_req_sequencer #(.NUM_CH(4), .FIFO_DEPTH(4), .ADDR_W(32), .CNT_W(4), .ARB_MODE(0)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c4_in_ready), .in_op(in_op),
    .in_addr(in_addr), .out_valid(c4_out_valid), .out_op(c4_out_op), .out_addr(c4_out_addr),
    .out_ch(c4_out_ch), .hold(hold), .rd_cnt(c4_rd), .wr_cnt(c4_wr), .snoop_cnt(c4_snoop),
    .illegal_cnt(c4_ill), .busy(c4_busy));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input logic [3:0] op, input logic [31:0] addr);
    in_valid[c]        = 1'b1;
    in_op[4*c +: 4]    = op;
    in_addr[32*c +: 32] = addr;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    hold     = 1'b0;
    in_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b1; hold = 1'b0; in_valid = '0; in_op = '0; in_addr = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_out_valid", 64'(rr_out_valid), 64'd0);
    chk("rst_busy",      64'(rr_busy),      64'd0);
    chk("rst_in_ready",  64'(rr_in_ready),  64'hF);
    chk("rst_out_addr",  64'(rr_out_addr),  64'd0);
    chk("rst_out_ch",    64'(rr_out_ch),    64'd0);
    chk("rst_rd_cnt",    64'(rr_rd),        64'd0);

    // 1: basic order and one-cycle latency
    do_reset();
    drive(0, 4'd0, 32'h1000);
    tick();
    chk("t1_not_yet_valid", 64'(rr_out_valid), 64'd0);
    chk("t1_busy",          64'(rr_busy),      64'd1);
    drive(0, 4'd1, 32'h1004);
    tick();
    chk("t1_valid",  64'(rr_out_valid), 64'd1);
    chk("t1_addr0",  64'(rr_out_addr),  64'h1000);
    chk("t1_op0",    64'(rr_out_op),    64'd0);
    in_valid = '0;
    tick();
    chk("t1_addr1",  64'(rr_out_addr),  64'h1004);
    chk("t1_op1",    64'(rr_out_op),    64'd1);
    chk("t1_rd_mid", 64'(rr_rd),        64'd1);
    tick();
    chk("t1_idle",   64'(rr_out_valid), 64'd0);
    chk("t1_rd",     64'(rr_rd),        64'd1);
    chk("t1_wr",     64'(rr_wr),        64'd1);
    chk("t1_busy0",  64'(rr_busy),      64'd0);

    // 2: round-robin across four simultaneous snoops
    do_reset();
    for (int c = 0; c < 4; c++) drive(c, 4'd4, 32'h2000 + 32'(c));
    tick();
    in_valid = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t2_rr_ch",   64'(rr_out_ch),   64'(c));
      chk("t2_rr_addr", 64'(rr_out_addr), 64'h2000 + 64'(c));
    end
    tick();
    chk("t2_idle",  64'(rr_out_valid), 64'd0);
    chk("t2_snoop", 64'(rr_snoop),     64'd4);

    // 2b: fixed priority keeps ch0 winning while it is refilled; RR alternates
    do_reset();
    drive(0, 4'd4, 32'hA0);
    drive(1, 4'd4, 32'hB0);
    tick();
    in_valid[1] = 1'b0;
    drive(0, 4'd4, 32'hA1);
    tick();
    chk("t2b_fp_ch_a0", 64'(fp_out_ch),   64'd0);
    chk("t2b_fp_a0",    64'(fp_out_addr), 64'hA0);
    drive(0, 4'd4, 32'hA2);
    tick();
    chk("t2b_fp_a1",    64'(fp_out_addr), 64'hA1);
    chk("t2b_rr_ch1",   64'(rr_out_ch),   64'd1);
    drive(0, 4'd4, 32'hA3);
    tick();
    chk("t2b_fp_a2",    64'(fp_out_addr), 64'hA2);
    in_valid = '0;
    tick();
    chk("t2b_fp_a3",    64'(fp_out_addr), 64'hA3);
    chk("t2b_fp_ch_a3", 64'(fp_out_ch),   64'd0);
    tick();
    chk("t2b_fp_b0",    64'(fp_out_addr), 64'hB0);
    chk("t2b_fp_ch_b0", 64'(fp_out_ch),   64'd1);

    // 3: hold stalls the presented request
    do_reset();
    hold = 1'b1;
    drive(2, 4'd2, 32'hABCD0000);
    tick();
    in_valid = '0;
    tick();
    chk("t3_valid", 64'(rr_out_valid), 64'd1);
    chk("t3_ch",    64'(rr_out_ch),    64'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_stable_valid", 64'(rr_out_valid), 64'd1);
      chk("t3_stable_addr",  64'(rr_out_addr),  64'hABCD0000);
      chk("t3_stable_op",    64'(rr_out_op),    64'd2);
      chk("t3_no_count",     64'(rr_rd),        64'd0);
    end
    hold = 1'b0;
    tick();
    chk("t3_accepted", 64'(rr_out_valid), 64'd0);
    chk("t3_rd_once",  64'(rr_rd),        64'd1);
    tick();
    chk("t3_rd_still", 64'(rr_rd),        64'd1);

    // 4: fill ch1 under hold, overflow request stalls, nothing lost or duplicated
    do_reset();
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1, 4'd0, 32'h100 + 32'(k));
      tick();
      if (k == 3) chk("t4_ready_before_full", 64'(rr_in_ready[1]), 64'd1);
    end
    chk("t4_full", 64'(rr_in_ready[1]), 64'd0);
    drive(1, 4'd0, 32'h105);
    tick();
    chk("t4_still_full", 64'(rr_in_ready[1]), 64'd0);
    chk("t4_head_held",  64'(rr_out_addr),    64'h100);
    hold = 1'b0;
    tick();
    chk("t4_addr101",    64'(rr_out_addr),    64'h101);
    chk("t4_ready_again",64'(rr_in_ready[1]), 64'd1);
    tick();
    in_valid = '0;
    chk("t4_addr102",    64'(rr_out_addr),    64'h102);
    for (int k = 3; k < 6; k++) begin
      tick();
      chk("t4_seq", 64'(rr_out_addr), 64'h100 + 64'(k));
    end
    tick();
    chk("t4_idle", 64'(rr_out_valid), 64'd0);
    chk("t4_rd6",  64'(rr_rd),        64'd6);

    // 5: illegal ops, clear wins over same-cycle illegal push, op 9 passes through
    do_reset();
    drive(0, 4'd7,  32'h70);
    drive(3, 4'd12, 32'hC0);
    tick();
    in_valid = '0;
    chk("t5_ill2",    64'(rr_ill),       64'd2);
    chk("t5_no_out",  64'(rr_out_valid), 64'd0);
    chk("t5_busy",    64'(rr_busy),      64'd0);
    tick();
    chk("t5_no_out2", 64'(rr_out_valid), 64'd0);
    drive(0, 4'd0, 32'h1);
    tick();
    drive(0, 4'd8, 32'h8);
    tick();
    in_valid = '0;
    chk("t5_op0",     64'(rr_out_op),    64'd0);
    tick();
    chk("t5_rd1",     64'(rr_rd),        64'd1);
    chk("t5_op8",     64'(rr_out_op),    64'd8);
    chk("t5_ill_pre", 64'(rr_ill),       64'd2);
    drive(2, 4'd7, 32'h77);
    tick();
    in_valid = '0;
    chk("t5_clr_rd",  64'(rr_rd),        64'd0);
    chk("t5_clr_ill", 64'(rr_ill),       64'd0);
    chk("t5_clr_idle",64'(rr_out_valid), 64'd0);
    drive(1, 4'd9, 32'h9);
    tick();
    in_valid = '0;
    tick();
    chk("t5_op9",     64'(rr_out_op),    64'd9);
    chk("t5_op9_ch",  64'(rr_out_ch),    64'd1);
    tick();
    chk("t5_op9_done",64'(rr_out_valid), 64'd0);
    chk("t5_op9_rd",  64'(rr_rd),        64'd0);
    chk("t5_op9_wr",  64'(rr_wr),        64'd0);
    chk("t5_op9_sn",  64'(rr_snoop),     64'd0);
    chk("t5_op9_ill", 64'(rr_ill),       64'd0);

    // 6: 4-bit counter saturation, then reset in the middle of traffic
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(0, 4'd0, 32'(k));
      tick();
    end
    in_valid = '0;
    w = 0;
    while (c4_busy && w < 10) begin
      tick();
      w++;
    end
    chk("t6_drain",  64'(c4_busy), 64'd0);
    chk("t6_sat15",  64'(c4_rd),   64'd15);
    chk("t6_rr20",   64'(rr_rd),   64'd20);
    drive(0, 4'd0, 32'h5);
    drive(1, 4'd1, 32'h6);
    tick();
    tick();
    chk("t6_pre_rst_valid", 64'(c4_out_valid), 64'd1);
    rst = 1'b1;
    in_valid = '0;
    tick();
    rst = 1'b0;
    chk("t6_rst_valid", 64'(c4_out_valid), 64'd0);
    chk("t6_rst_busy",  64'(c4_busy),      64'd0);
    chk("t6_rst_ready", 64'(c4_in_ready),  64'hF);
    chk("t6_rst_rd",    64'(c4_rd),        64'd0);
    tick();
    chk("t6_discard_valid", 64'(c4_out_valid), 64'd0);
    chk("t6_discard_busy",  64'(c4_busy),      64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
